// File: rtl/udma_hyper_rx_ctrl.sv
// Read-transfer sequencer for the HyperBus/PSRAM/32-bit PHY RX path: issues one PHY burst,
// steers the 16b/32b width-adaptation buffer and counts words handed to the uDMA FIFO.
module udma_hyper_rx_ctrl #(
    parameter int TRANS_SIZE  = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [31:0]           req_addr_i,
    input  logic [TRANS_SIZE-1:0] req_size_i,
    input  logic [1:0]            req_mem_sel_i,
    input  logic                  abort_i,
    output logic                  phy_req_valid_o,
    input  logic                  phy_req_ready_i,
    output logic [31:0]           phy_addr_o,
    output logic [TRANS_SIZE-1:0] phy_len_o,
    input  logic                  phy_rx_valid_i,
    input  logic                  rx_ready_i,
    input  logic                  buf_dst_valid_i,
    input  logic                  buf_dst_ready_i,
    output logic [TRANS_SIZE-1:0] remained_data_o,
    output logic                  odd_saaddr_o,
    output logic [TRANS_SIZE-1:0] rx_size_o,
    output logic [1:0]            mem_sel_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);
    localparam int CW = TRANS_SIZE + 2;
    localparam int IW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [2:0] {IDLE, ISSUE, RECV, DRAIN, FIN} state_t;

    state_t                state_reg, state_next;
    logic [31:0]           addr_reg;
    logic [TRANS_SIZE-1:0] len_reg, remained_reg, size_reg;
    logic                  odd_reg, err_reg, fin_err;
    logic [1:0]            mem_sel_reg;
    logic [CW-1:0]         words_reg, word_cnt_reg, word_cnt_inc;
    logic [IW-1:0]         idle_cnt_reg;

    logic                  is32, odd_new, in_rx, beat_hs, word_hs, timeout_hit, accept;
    logic [CW-1:0]         size_ext, beats_ext, words_ext;
    logic [31:0]           addr_aligned;
    logic [TRANS_SIZE-1:0] remained_dec;

    // Descriptor decode: 32-bit PHY works in 4-byte beats, the 16-bit memories in 2-byte beats
    always_comb begin
        size_ext     = CW'(req_size_i);
        is32         = (req_mem_sel_i == 2'b11);
        odd_new      = is32 ? req_addr_i[1] : req_addr_i[0];
        addr_aligned = is32 ? {req_addr_i[31:2], 2'b00} : {req_addr_i[31:1], 1'b0};
        if (is32)
            beats_ext = (size_ext + {{(CW-2){1'b0}}, odd_new, 1'b0} + CW'(3)) >> 2;
        else
            beats_ext = (size_ext + {{(CW-1){1'b0}}, odd_new} + CW'(1)) >> 1;
        words_ext = (size_ext + CW'(3)) >> 2;
    end

    assign accept       = (state_reg == IDLE) && req_valid_i;
    assign in_rx        = (state_reg == RECV) || (state_reg == DRAIN);
    assign beat_hs      = (state_reg == RECV) && phy_rx_valid_i && rx_ready_i && (remained_reg != '0);
    assign word_hs      = in_rx && buf_dst_valid_i && buf_dst_ready_i;
    assign remained_dec = remained_reg - TRANS_SIZE'(beat_hs);
    assign word_cnt_inc = word_cnt_reg + CW'(word_hs);
    assign timeout_hit  = (TIMEOUT_CYC != 0) && in_rx && !beat_hs && !word_hs &&
                          ({{(32-IW){1'b0}}, idle_cnt_reg} == 32'(TIMEOUT_CYC - 1));

    always_comb begin
        state_next = state_reg;
        fin_err    = 1'b0;
        case (state_reg)
            IDLE:  if (req_valid_i) state_next = (req_size_i == '0) ? FIN : ISSUE;
            ISSUE: if (phy_req_ready_i) state_next = RECV;
            RECV:  if (remained_dec == '0) state_next = (word_cnt_inc >= words_reg) ? FIN : DRAIN;
            DRAIN: if (word_cnt_inc >= words_reg) state_next = FIN;
            FIN:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // Abort outranks a completion landing in the same cycle
        if (timeout_hit || (abort_i && state_reg != IDLE && state_reg != FIN)) begin
            state_next = FIN;
            fin_err    = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg    <= IDLE;
            addr_reg     <= '0;
            len_reg      <= '0;
            remained_reg <= '0;
            odd_reg      <= 1'b0;
            size_reg     <= '0;
            mem_sel_reg  <= '0;
            words_reg    <= '0;
            word_cnt_reg <= '0;
            idle_cnt_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                size_reg     <= req_size_i;
                mem_sel_reg  <= req_mem_sel_i;
                words_reg    <= words_ext;
                word_cnt_reg <= '0;
                idle_cnt_reg <= '0;
                err_reg      <= 1'b0;
                if (req_size_i != '0) begin
                    addr_reg     <= addr_aligned;
                    len_reg      <= beats_ext[TRANS_SIZE-1:0];
                    remained_reg <= beats_ext[TRANS_SIZE-1:0];
                    odd_reg      <= odd_new;
                end
            end else if (state_next == FIN && state_reg != FIN) begin
                // Zeroing remained_data_o also releases the buffer's select flop after an abort
                addr_reg     <= '0;
                len_reg      <= '0;
                remained_reg <= '0;
                odd_reg      <= 1'b0;
                word_cnt_reg <= '0;
                idle_cnt_reg <= '0;
                err_reg      <= fin_err;
            end else begin
                remained_reg <= remained_dec;
                word_cnt_reg <= word_cnt_inc;
                if (!in_rx || beat_hs || word_hs)
                    idle_cnt_reg <= '0;
                else
                    idle_cnt_reg <= idle_cnt_reg + IW'(1);
            end
        end
    end

    assign req_ready_o     = (state_reg == IDLE);
    assign phy_req_valid_o = (state_reg == ISSUE);
    assign busy_o          = (state_reg != IDLE);
    assign done_o          = (state_reg == FIN);
    assign err_o           = (state_reg == FIN) && err_reg;
    assign phy_addr_o      = addr_reg;
    assign phy_len_o       = len_reg;
    assign remained_data_o = remained_reg;
    assign odd_saaddr_o    = odd_reg;
    assign rx_size_o       = size_reg;
    assign mem_sel_o       = mem_sel_reg;
endmodule
